fetch_sequencer: RTL and testbench

Instruction-fetch and program-sequencing stage of the 8-bit RISC processor. Holds the program counter (PC) and instruction register (IR), runs the fetch/decode/execute state machine and produces the two candidate memory addresses plus the select that drive the downstream 8-bit 2:1 address multiplexer. It runs one instruction every three cycles until a halt opcode is executed.

---
 rtl/risc_pkg.sv | 36 +++
 rtl/fetch_sequencer_if.sv | 39 +++
 rtl/fetch_pc.sv | 45 ++++
 rtl/fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : risc_pkg
//  Description : Shared definitions for the 8-bit RISC fetch/sequencing stage:
//                opcode values, FSM state encoding and the operand-read
//                decode helper.
//  Config      : FETCH_SKZ_EN is not used in this file.
//  Revision    : 1.0 - initial release
// ============================================================================
package risc_pkg;

    localparam int IR_W = 8;

    localparam logic [2:0] HLT = 3'b000;
    localparam logic [2:0] SKZ = 3'b001;
    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] AND = 3'b011;
    localparam logic [2:0] XOR = 3'b100;
    localparam logic [2:0] LDA = 3'b101;
    localparam logic [2:0] STO = 3'b110;
    localparam logic [2:0] JMP = 3'b111;

    typedef enum logic [1:0] {
        FETCH  = 2'b00,
        DECODE = 2'b01,
        EXEC   = 2'b10,
        HALT   = 2'b11
    } state_t;

    // Opcodes that read a data operand from memory at the IR operand address.
    function automatic logic needs_operand(input logic [2:0] op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer_if
//  Description : Memory-side bus of the fetch sequencer.
//                mem_rdata : read data from combinational memory (8 bits)
//                pc_addr   : address-mux input 0 (current PC)
//                ir_addr   : address-mux input 1 (zero-extended IR operand)
//                addr_sel  : address-mux select, 0 = pc_addr, 1 = ir_addr
//                mem_rd    : memory read strobe
//                master = sequencer side, slave = memory / mux side.
//  Config      : FETCH_SKZ_EN is not used in this file.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        mem_rdata;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] ir_addr;
    logic              addr_sel;
    logic              mem_rd;

    modport master (
        input  mem_rdata,
        output pc_addr,
        output ir_addr,
        output addr_sel,
        output mem_rd
    );

    modport slave (
        output mem_rdata,
        input  pc_addr,
        input  ir_addr,
        input  addr_sel,
        input  mem_rd
    );
endinterface
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pc
//  Description : Program counter register, modulo 2^ADDR_W arithmetic.
//                clk, rst_n : clock, asynchronous active-low reset (PC -> 0)
//                load       : PC <= load_val (highest priority)
//                inc2       : PC <= PC + 2   (only with FETCH_SKZ_EN)
//                inc1       : PC <= PC + 1   (lowest priority)
//                pc         : current PC
//  Config      : FETCH_SKZ_EN - keeps the +2 path; otherwise inc2 is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc #(
    parameter int ADDR_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              inc1,
    input  wire logic              inc2,
    input  wire logic              load,
    input  wire logic [ADDR_W-1:0] load_val,
    output logic      [ADDR_W-1:0] pc
);

`ifndef FETCH_SKZ_EN
    logic unused_inc2;
    assign unused_inc2 = inc2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (load) begin
            pc <= load_val;
`ifdef FETCH_SKZ_EN
        end else if (inc2) begin
            pc <= pc + ADDR_W'(2);
`endif
        end else if (inc1) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Instruction fetch / program sequencing stage. Holds PC and IR,
//                runs FETCH -> DECODE -> EXEC (-> HALT) and drives the two
//                candidate addresses plus select of the external 2:1 mux.
//                clk, rst_n : clock, asynchronous active-low reset
//                bus        : memory bus (fetch_sequencer_if.master)
//                zero       : accumulator-is-zero flag (SKZ condition)
//                resume     : leave HALT
//                opcode     : IR[7:5]
//                ir_load    : IR latches on this cycle's closing edge
//                exec       : ALU/accumulator commit cycle
//                halted     : sequencer is in HALT
//  Config      : FETCH_SKZ_EN - SKZ skips when zero=1; otherwise SKZ is a NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_sequencer
    import risc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int OPND_W = 5
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    fetch_sequencer_if.master bus,
    input  wire logic        zero,
    input  wire logic        resume,
    output logic [2:0]       opcode,
    output logic             ir_load,
    output logic             exec,
    output logic             halted
);

    state_t            state;
    logic [IR_W-1:0]   ir;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] operand_addr;

    // Strobes are registered alongside the state so each one is valid for
    // exactly the state it belongs to, with no path from any input.
    logic addr_sel_q;
    logic mem_rd_q;
    logic ir_load_q;
    logic exec_q;
    logic halted_q;

    logic pc_inc1;
    logic pc_inc2;
    logic pc_load;

    assign opcode       = ir[7:5];
    assign operand_addr = ADDR_W'(ir[OPND_W-1:0]);

    // PC control is only active in EXEC (and HALT for resume). SKZ raises
    // inc1 as well; the PC's priority lets inc2 win when the skip is taken.
    assign pc_inc1 = ((state == EXEC) && (opcode != HLT) && (opcode != JMP)) ||
                     ((state == HALT) && resume);
    assign pc_load = (state == EXEC) && (opcode == JMP);

`ifdef FETCH_SKZ_EN
    assign pc_inc2 = (state == EXEC) && (opcode == SKZ) && zero;
`else
    logic unused_zero;
    assign unused_zero = zero;
    assign pc_inc2     = 1'b0;
`endif

    fetch_pc #(
        .ADDR_W   (ADDR_W)
    ) u_fetch_pc (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc1     (pc_inc1),
        .inc2     (pc_inc2),
        .load     (pc_load),
        .load_val (operand_addr),
        .pc       (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            ir         <= '0;
            addr_sel_q <= 1'b0;
            mem_rd_q   <= 1'b1;
            ir_load_q  <= 1'b1;
            exec_q     <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    ir         <= bus.mem_rdata;
                    state      <= DECODE;
                    addr_sel_q <= 1'b1;
                    // Operand read decision uses the opcode being latched.
                    mem_rd_q   <= needs_operand(bus.mem_rdata[7:5]);
                    ir_load_q  <= 1'b0;
                end
                DECODE: begin
                    state  <= EXEC;
                    exec_q <= 1'b1;
                end
                EXEC: begin
                    exec_q     <= 1'b0;
                    addr_sel_q <= 1'b0;
                    if (opcode == HLT) begin
                        state    <= HALT;
                        mem_rd_q <= 1'b0;
                        halted_q <= 1'b1;
                    end else begin
                        state     <= FETCH;
                        mem_rd_q  <= 1'b1;
                        ir_load_q <= 1'b1;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state     <= FETCH;
                        mem_rd_q  <= 1'b1;
                        ir_load_q <= 1'b1;
                        halted_q  <= 1'b0;
                    end
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign bus.pc_addr  = pc;
    assign bus.ir_addr  = operand_addr;
    assign bus.addr_sel = addr_sel_q;
    assign bus.mem_rd   = mem_rd_q;
    assign ir_load      = ir_load_q;
    assign exec         = exec_q;
    assign halted       = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer with a
//                256-byte combinational memory behind the 2:1 address mux.
//  Config      : FETCH_SKZ_EN - selects the SKZ expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

`ifdef FETCH_SKZ_EN
    localparam bit SKZ_ON = 1'b1;
`else
    localparam bit SKZ_ON = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       zero;
    logic       resume;
    logic [2:0] opcode;
    logic       ir_load;
    logic       exec;
    logic       halted;

    logic [7:0] mem [256];
    logic [7:0] mux_addr;

    int assertions;
    int failures;

    fetch_sequencer_if #(.ADDR_W(8)) bus ();

    fetch_sequencer #(
        .ADDR_W  (8),
        .OPND_W  (5)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .zero    (zero),
        .resume  (resume),
        .opcode  (opcode),
        .ir_load (ir_load),
        .exec    (exec),
        .halted  (halted)
    );

    assign mux_addr      = bus.addr_sel ? bus.ir_addr : bus.pc_addr;
    assign bus.mem_rdata = mem[mux_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        assertions++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    // Leaves the DUT in FETCH at a falling edge.
    task automatic do_reset();
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
    endtask

    initial begin
        assertions = 0;
        failures   = 0;
        rst_n      = 1'b0;
        zero       = 1'b0;
        resume     = 1'b0;
        fill(8'hC0);

        // ---- reset state, JMP 5 at 0 ----
        mem[0] = 8'hE5;
        run(2);
        check_value("rst_pc_addr",  bus.pc_addr,  8'h00);
        check_value("rst_ir_addr",  bus.ir_addr,  8'h00);
        check_value("rst_opcode",   opcode,       3'b000);
        check_value("rst_addr_sel", bus.addr_sel, 1'b0);
        check_value("rst_mem_rd",   bus.mem_rd,   1'b1);
        check_value("rst_ir_load",  ir_load,      1'b1);
        check_value("rst_exec",     exec,         1'b0);
        check_value("rst_halted",   halted,       1'b0);
        rst_n = 1'b1;
        run(1);
        check_value("jmp_dec_opcode",  opcode,       3'b111);
        check_value("jmp_dec_ir_addr", bus.ir_addr,  8'h05);
        check_value("jmp_dec_sel",     bus.addr_sel, 1'b1);
        check_value("jmp_dec_mem_rd",  bus.mem_rd,   1'b0);
        run(1);
        check_value("jmp_exec",        exec,         1'b1);
        run(1);
        check_value("jmp_new_pc",      bus.pc_addr,  8'h05);
        check_value("jmp_fetch_load",  ir_load,      1'b1);

        // ---- sequential ADD, LDA, STO ----
        fill(8'hC0);
        mem[0] = 8'h43;
        mem[1] = 8'hA4;
        mem[2] = 8'hC6;
        do_reset();
        check_value("seq_pc0", bus.pc_addr, 8'h00);
        run(1);
        check_value("seq_rd_add", bus.mem_rd, 1'b1);
        run(2);
        check_value("seq_pc1", bus.pc_addr, 8'h01);
        run(1);
        check_value("seq_rd_lda", bus.mem_rd, 1'b1);
        run(2);
        check_value("seq_pc2", bus.pc_addr, 8'h02);
        run(1);
        check_value("seq_rd_sto", bus.mem_rd, 1'b0);
        run(2);
        check_value("seq_pc3", bus.pc_addr, 8'h03);

        // ---- SKZ at 0x10, taken then not taken ----
        fill(8'hC0);
        mem[0]    = 8'hF0;
        mem[8'h10] = 8'h20;
        zero = 1'b1;
        do_reset();
        run(3);
        check_value("skz_at_10", bus.pc_addr, 8'h10);
        run(3);
        check_value("skz_taken", bus.pc_addr, SKZ_ON ? 8'h12 : 8'h11);
        zero = 1'b0;
        do_reset();
        run(6);
        check_value("skz_not_taken", bus.pc_addr, 8'h11);

        // ---- halt / resume: HLT at 0x07 ----
        fill(8'hC0);
        mem[0] = 8'hE7;
        mem[7] = 8'h00;
        do_reset();
        run(3);
        check_value("hlt_pc", bus.pc_addr, 8'h07);
        run(2);
        check_value("hlt_exec",        exec,   1'b1);
        check_value("hlt_not_yet",     halted, 1'b0);
        run(1);
        check_value("hlt_halted",      halted, 1'b1);
        check_value("hlt_mem_rd",      bus.mem_rd, 1'b0);
        check_value("hlt_sel",         bus.addr_sel, 1'b0);
        for (int i = 0; i < 10; i++) begin
            run(1);
            check_value("hlt_hold_halted", halted,      1'b1);
            check_value("hlt_hold_pc",     bus.pc_addr, 8'h07);
        end
        resume = 1'b1;
        run(1);
        resume = 1'b0;
        check_value("resume_pc",      bus.pc_addr, 8'h08);
        check_value("resume_halted",  halted,      1'b0);
        check_value("resume_ir_load", ir_load,     1'b1);
        resume = 1'b1;
        run(1);
        resume = 1'b0;
        check_value("fetch_resume_decode", bus.addr_sel, 1'b1);
        check_value("fetch_resume_pc",     bus.pc_addr,  8'h08);
        run(2);
        check_value("fetch_resume_next",   bus.pc_addr,  8'h09);

        // ---- reset during EXEC of JMP 0x1F ----
        fill(8'hC0);
        mem[0] = 8'hFF;
        do_reset();
        run(2);
        check_value("mid_exec", exec, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_value("mid_pc_async",  bus.pc_addr,  8'h00);
        check_value("mid_ir_load",   ir_load,      1'b1);
        check_value("mid_exec_low",  exec,         1'b0);
        check_value("mid_sel",       bus.addr_sel, 1'b0);
        check_value("mid_ir_addr",   bus.ir_addr,  8'h00);
        run(1);
        check_value("mid_pc_held",   bus.pc_addr,  8'h00);
        rst_n = 1'b1;

        // ---- wrap-around: STO at 0xFF, then SKZ taken at 0xFF ----
        fill(8'hC0);
        do_reset();
        run(3 * 255);
        check_value("wrap_at_ff", bus.pc_addr, 8'hFF);
        run(3);
        check_value("wrap_inc1",  bus.pc_addr, 8'h00);
        fill(8'hC0);
        mem[8'hFF] = 8'h20;
        zero = 1'b1;
        do_reset();
        run(3 * 255);
        check_value("wrap_skz_ff", bus.pc_addr, 8'hFF);
        run(3);
        check_value("wrap_skz",    bus.pc_addr, SKZ_ON ? 8'h01 : 8'h00);
        zero = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions, failures);
        $finish;
    end

endmodule
`default_nettype wire
